alu_seq: RTL and testbench

Parametrised, handshaked successor to the 8-bit add-only ALU. It executes one of eight operations per transaction on two WIDTH-bit operands and returns a registered result with a four-bit flag vector. Multiply runs iteratively; every other operation completes in one cycle. It sits between the instruction decoder/register-file read stage and write-back, with valid/ready on both sides so a multi-cycle op stalls the datapath cleanly.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/cla_nbit.sv | 59 +++++
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode encodings, flag bit
// positions within the 4-bit flag vector, and the controller state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   // Flag vector layout: {C, V, Z, N}
   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_nbit.sv
// ----------------------------------------------------------------------------
// cla_nbit
// WIDTH-bit carry-lookahead adder. Every carry is formed directly from the
// generate/propagate terms and the carry-in, so no carry depends on another.
// Ports:
//   A, B  in  WIDTH  addends
//   Ci    in  1      carry-in
//   S     out WIDTH  sum
//   Co    out 1      carry-out of the MSB
//   OF    out 1      two's-complement overflow
// ----------------------------------------------------------------------------
module cla_nbit #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             OF
);

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;
   logic             prod;
   logic             csum;

   always_comb begin
      g    = A & B;
      p    = A ^ B;
      c    = '0;
      prod = 1'b0;
      csum = 1'b0;
      c[0] = Ci;
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]Ci
      for (int i = 0; i < WIDTH; i++) begin
         prod = Ci;
         for (int k = 0; k <= i; k++) begin
            prod = prod & p[k];
         end
         csum = prod;
         for (int j = 0; j <= i; j++) begin
            prod = g[j];
            for (int k = j + 1; k <= i; k++) begin
               prod = prod & p[k];
            end
            csum = csum | prod;
         end
         c[i+1] = csum;
      end
   end

   assign S  = p ^ c[WIDTH-1:0];
   assign Co = c[WIDTH];
   // Overflow when carry into the sign bit differs from carry out of it
   assign OF = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
// Handshaked ALU: eight operations on two WIDTH-bit operands, registered
// result and {C,V,Z,N} flags. MUL is an iterative shift-add taking WIDTH
// cycles; every other operation completes in the accepting cycle.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-high reset
//   in_valid   in  1      opcode/operands present
//   in_ready   out 1      high only while idle
//   op         in  3      opcode (alu_pkg OP_*)
//   operand1   in  WIDTH  operand A
//   operand2   in  WIDTH  operand B
//   out_valid  out 1      result/flags valid
//   out_ready  in  1      consumer takes result
//   result     out WIDTH  registered result
//   flags      out 4      registered {C,V,Z,N}
// ----------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   // {partial-product high half, remaining multiplier bits}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [SW-1:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0]   add_a, add_b, add_s;
   logic               add_ci, add_co, add_of;
   logic [2*WIDTH-1:0] acc_step;

   logic [SW-1:0]      shamt;
   logic [2*WIDTH-1:0] shl_full, shr_full;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   function automatic logic [3:0] make_flags(input logic c, input logic v,
                                             input logic [WIDTH-1:0] r);
      logic [3:0] f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_Z] = (r == '0);
      f[FLAG_N] = r[WIDTH-1];
      return f;
   endfunction

   // One adder serves ADD/SUB while idle and the partial sums while multiplying
   always_comb begin
      if (state_q == ST_MUL) begin
         add_a  = acc_q[2*WIDTH-1:WIDTH];
         add_b  = acc_q[0] ? mcand_q : '0;
         add_ci = 1'b0;
      end else begin
         add_a  = operand1;
         add_b  = (op == OP_SUB) ? ~operand2 : operand2;
         add_ci = (op == OP_SUB);
      end
   end

   cla_nbit #(.WIDTH(WIDTH)) u_cla (
      .A  (add_a),
      .B  (add_b),
      .Ci (add_ci),
      .S  (add_s),
      .Co (add_co),
      .OF (add_of)
   );

   // Shift-add step: add multiplicand into the high half, then shift the
   // whole accumulator (including the adder carry) right by one.
   assign acc_step = {add_co, add_s, acc_q[WIDTH-1:1]};

   // Shifts are done in a double-width field so the last bit shifted out
   // lands at a fixed position next to the result.
   assign shamt    = operand2[SW-1:0];
   assign shl_full = {{WIDTH{1'b0}}, operand1} << shamt;
   assign shr_full = {operand1, {WIDTH{1'b0}}} >> shamt;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_res = add_s;
            alu_c   = add_co;
            alu_v   = add_of;
         end
         OP_AND: alu_res = operand1 & operand2;
         OP_OR:  alu_res = operand1 | operand2;
         OP_XOR: alu_res = operand1 ^ operand2;
         OP_SHL: begin
            alu_res = shl_full[WIDTH-1:0];
            alu_c   = (shamt != '0) & shl_full[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_full[2*WIDTH-1:WIDTH];
            alu_c   = (shamt != '0) & shr_full[WIDTH-1];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (op == OP_MUL) begin
                  mcand_d = operand1;
                  acc_d   = {{WIDTH{1'b0}}, operand2};
                  cnt_d   = '0;
                  state_d = ST_MUL;
               end else begin
                  result_d = alu_res;
                  flags_d  = make_flags(alu_c, alu_v, alu_res);
                  state_d  = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            acc_d = acc_step;
            if (cnt_q == SW'(WIDTH - 1)) begin
               result_d = acc_step[WIDTH-1:0];
               flags_d  = make_flags(|acc_step[2*WIDTH-1:WIDTH],
                                     |acc_step[2*WIDTH-1:WIDTH],
                                     acc_step[WIDTH-1:0]);
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq (WIDTH=8): directed cases plus randomized
// traffic with random backpressure, checked against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
      int           lat;
      int           acc_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] operand1 = '0;
   logic [W-1:0] operand2 = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rand_bp = 1'b0;
   bit   prev_v = 1'b0;
   bit   prev_rdy = 1'b0;
   exp_t sb[$];
   exp_t cur;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand1  (operand1),
      .operand2  (operand2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model from the arithmetic definitions of each opcode
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint full, ua, ub, sa, sbv, r, s;
      int     amt;
      logic   c, v;
      full = longint'(1) << W;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = (ua >= full / 2) ? ua - full : ua;
      sbv  = (ub >= full / 2) ? ub - full : ub;
      amt  = int'(ub % W);
      c    = 1'b0;
      v    = 1'b0;
      r    = 0;
      case (o)
         3'd0: begin
            r = ua + ub;  c = (r >= full);
            s = sa + sbv; v = (s > full / 2 - 1) || (s < -(full / 2));
         end
         3'd1: begin
            r = ua + (full - 1 - ub) + 1; c = (r >= full);
            s = sa - sbv; v = (s > full / 2 - 1) || (s < -(full / 2));
         end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: begin
            r = ua * (longint'(1) << amt);
            c = (amt != 0) && (((r / full) % 2) == 1);
         end
         3'd6: begin
            r = ua / (longint'(1) << amt);
            c = (amt != 0) && (((ua / (longint'(1) << (amt - 1))) % 2) == 1);
         end
         default: begin
            r = ua * ub; c = (r >= full); v = c;
         end
      endcase
      e.res     = r[W-1:0];
      e.flg     = {c, v, (e.res == '0), e.res[W-1]};
      e.lat     = (o == 3'd7) ? W + 1 : 1;
      e.acc_cyc = 0;
      return e;
   endfunction

   // Monitor: pops on each new result and checks it while it is presented
   always @(negedge clk) begin
      if (reset) begin
         prev_v   = 1'b0;
         prev_rdy = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               cur = sb.pop_front();
               check("result", 64'(result), 64'(cur.res));
               check("flags", 64'(flags), 64'(cur.flg));
               check("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
               check("in_ready_done", 64'(in_ready), 64'd0);
            end
         end else if (out_valid && prev_v) begin
            check("result_hold", 64'(result), 64'(cur.res));
            check("flags_hold", 64'(flags), 64'(cur.flg));
            check("in_ready_hold", 64'(in_ready), 64'd0);
         end else if (!out_valid && prev_v) begin
            check("released_with_ready", 64'(prev_rdy), 64'd1);
            check("in_ready_after_release", 64'(in_ready), 64'd1);
         end
         prev_v   = out_valid;
         prev_rdy = out_ready;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
   end

   // All stimulus changes happen 1 time unit after a rising edge
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   n;
      n = 0;
      while (!in_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
      else begin
         op       = o;
         operand1 = a;
         operand2 = b;
         in_valid = 1'b1;
         e         = model(o, a, b);
         e.acc_cyc = cyc;
         sb.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
         op       = 3'($urandom);
         operand1 = W'($urandom);
         operand2 = W'($urandom);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 64'(sb.size() == 0 && in_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_result"}, 64'(result), 64'd0);
      check({tag, "_flags"}, 64'(flags), 64'd0);
   endtask

   initial begin
      int n;
      @(posedge clk); #1;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      issue(3'd0, 8'h7F, 8'h01); drain();
      issue(3'd1, 8'h05, 8'h05); drain();
      issue(3'd1, 8'h00, 8'h01); drain();

      issue(3'd7, 8'h10, 8'h11);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         op       = 3'($urandom);
         operand1 = W'($urandom);
         operand2 = W'($urandom);
         check("in_ready_during_mul", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      drain();
      issue(3'd7, 8'h0F, 8'h0F); drain();

      issue(3'd5, 8'h81, 8'h01); drain();
      issue(3'd6, 8'h81, 8'h09); drain();
      issue(3'd4, 8'hAA, 8'hAA); drain();
      issue(3'd5, 8'h81, 8'h00); drain();
      issue(3'd6, 8'h80, 8'h07); drain();

      // Backpressure: hold the result for 5 cycles, then one release pulse
      out_ready = 1'b0;
      issue(3'd0, 8'h3C, 8'h4A);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_out_valid", 64'(out_valid), 64'd1);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("bp_still_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      drain();

      // Reset in the middle of a multiply
      issue(3'd7, 8'h10, 8'h11);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      check_reset_outputs("midmul_reset");
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      issue(3'd0, 8'h01, 8'h01); drain();

      // Randomized traffic with random backpressure
      rand_bp = 1'b1;
      repeat (200) begin
         issue(3'($urandom), W'($urandom), W'($urandom));
      end
      @(posedge clk); #1;
      rand_bp   = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
